// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Purpose  : Run-time programmable 50%-duty clock divider. A new divide ratio
//            arrives over a valid/ready handshake and is held pending until
//            the current divided period ends, so clkout never glitches.
//            Odd ratios combine a posedge phase and a negedge phase. Even
//            ratios use the posedge phase only.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        width of divide ratio / period counter (legal ratio 2..2^CNT_W-1)
//   DEFAULT_DIV  ratio loaded at reset (must be within the legal range)
// Ports
//   clk        in   source clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   new ratio request
//   req_div    in   requested ratio
//   run        in   divider enable (present only with CLK_DIV_SCHED_STOP_EN)
//   req_ready  out  scheduler can accept a request
//   busy       out  a ratio change is pending
//   cur_div    out  ratio currently in effect
//   err        out  1-cycle pulse: rejected request (req_div < 2)
//   tick       out  1-cycle pulse: first clk cycle of each divided period
//   clkout     out  divided clock
// Configuration macro
//   CLK_DIV_SCHED_STOP_EN : adds input run. The divider parks low at a period
//                           boundary while run is 0.
// ============================================================================
module clk_div_sched #(
  parameter int CNT_W       = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_div,
`ifdef CLK_DIV_SCHED_STOP_EN
  input  logic             run,
`endif
  output logic             req_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             err,
  output logic             tick,
  output logic             clkout
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(DEFAULT_DIV - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pend_div, pend_nxt;
  logic [CNT_W-1:0] div_nxt;
  logic             ph_p, ph_p_nxt;
  logic             ph_n;
  logic             tick_nxt;
  logic             boundary;
  logic             apply;
  logic             accept;
  logic             reject;
`ifdef CLK_DIV_SCHED_STOP_EN
  logic             parked, park_nxt;
`endif

  // Number of counter values for which the posedge phase is high: ceil(d/2).
  // One extra bit keeps the result exact for the largest ratio.
  function automatic logic [CNT_W:0] high_len(input logic [CNT_W-1:0] d);
    high_len = ({1'b0, d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_div;
    div_nxt   = cur_div;
    cnt_nxt   = cnt + ONE;
    apply     = 1'b0;
    boundary  = (cnt == (cur_div - ONE));
    req_ready = (state == ST_RUN);
    busy      = (state == ST_PEND);
    accept    = req_valid & req_ready & (req_div >= TWO);
    reject    = req_valid & req_ready & (req_div <  TWO);
`ifdef CLK_DIV_SCHED_STOP_EN
    park_nxt  = parked;
    if (parked) begin
      // Hold at the start of a period. Leaving park behaves like a boundary,
      // so a pending ratio takes effect on the very first new period.
      cnt_nxt = '0;
      if (run) begin
        park_nxt = 1'b0;
        apply    = 1'b1;
      end
    end else if (boundary) begin
      cnt_nxt = '0;
      if (run) begin
        apply = 1'b1;
      end else begin
        park_nxt = 1'b1;
      end
    end
`else
    if (boundary) begin
      cnt_nxt = '0;
      apply   = 1'b1;
    end
`endif

    case (state)
      ST_RUN: begin
        if (accept) begin
          pend_nxt  = req_div;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        // Requests are not accepted here. req_ready is low, so no err either.
        if (apply) begin
          div_nxt   = pend_div;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    // Phase and tick are computed from the post-edge counter and ratio, so a
    // ratio switch starts the new period with the new high length.
    tick_nxt = (cnt_nxt == '0);
    ph_p_nxt = ({1'b0, cnt_nxt} < high_len(div_nxt));
`ifdef CLK_DIV_SCHED_STOP_EN
    tick_nxt = tick_nxt & ~park_nxt;
    ph_p_nxt = ph_p_nxt & ~park_nxt;
`endif
  end

  // --------------------------------------------------------------------------
  // Posedge state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      cnt      <= CNT_RST;
      cur_div  <= DIV_RST;
      pend_div <= DIV_RST;
      ph_p     <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_div  <= div_nxt;
      pend_div <= pend_nxt;
      ph_p     <= ph_p_nxt;
      tick     <= tick_nxt;
      err      <= reject;
    end
  end

`ifdef CLK_DIV_SCHED_STOP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parked <= 1'b0;
    end else begin
      parked <= park_nxt;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Negedge phase: ph_p delayed by half a clk period. ph_p is always low in
  // the last counter value of a period, so ph_n is already low when the ratio
  // changes. An odd-to-even switch therefore cannot leave a stale high half.
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ph_n <= 1'b0;
    end else begin
      ph_n <= ph_p;
    end
  end

  // Odd ratio: the AND of the two phases trims the high time by half a cycle,
  // giving d/2 clk periods high. Even ratio: ph_p alone is already d/2.
  assign clkout = cur_div[0] ? (ph_p & ph_n) : ph_p;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Purpose  : Scoreboard bench for clk_div_sched. The driver issues directed and
//            random requests and resets, advances a period-level reference
//            model, and pushes the expected per-cycle response. A separate
//            monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_sched;

  localparam int CNT_W       = 4;
  localparam int DEFAULT_DIV = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [CNT_W-1:0] req_div = '0;
  logic             req_ready;
  logic             busy;
  logic [CNT_W-1:0] cur_div;
  logic             err;
  logic             tick;
  logic             clkout;
`ifdef CLK_DIV_SCHED_STOP_EN
  logic             run = 1'b1;
`endif

  clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_div   (req_div),
`ifdef CLK_DIV_SCHED_STOP_EN
    .run       (run),
`endif
    .req_ready (req_ready),
    .busy      (busy),
    .cur_div   (cur_div),
    .err       (err),
    .tick      (tick),
    .clkout    (clkout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             tick;
    logic [CNT_W-1:0] div;
    logic             busy;
    logic             ready;
    logic             err;
    logic             c1;   // clkout in the first half of the cycle
    logic             c2;   // clkout in the second half of the cycle
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: the ratio in effect, the cycle index inside the
  // current divided period, the pending ratio (-1 when none) and the err flag.
  int m_div, m_pos, m_pend;
  bit m_err;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div  = DEFAULT_DIV;
    m_pos  = DEFAULT_DIV - 1;
    m_pend = -1;
    m_err  = 1'b0;
  endtask

  // A divided clock with ratio d is high for d half-cycles per period.
  // Even ratios start high at the period start. Odd ratios start half a
  // cycle later.
  function automatic bit half_high(int d, int h);
    int st;
    st = d % 2;
    return (h >= st) && (h < st + d);
  endfunction

  task automatic model_step(input bit v, input int d, input bit r);
    exp_t e;
    bit   bnd, rdy;
    if (!r) begin
      bnd = (m_pos == m_div - 1);
      rdy = (m_pend < 0);
      if (bnd) begin
        m_pos = 0;
        if (m_pend >= 0) begin
          m_div  = m_pend;
          m_pend = -1;
        end
      end else begin
        m_pos++;
      end
      m_err = v && rdy && (d < 2);
      if (v && rdy && d >= 2) m_pend = d;
    end
    e.tick  = !r && (m_pos == 0);
    e.div   = CNT_W'(m_div);
    e.busy  = (m_pend >= 0);
    e.ready = (m_pend < 0);
    e.err   = m_err;
    e.c1    = !r && half_high(m_div, 2 * m_pos);
    e.c2    = !r && half_high(m_div, 2 * m_pos + 1);
    q.push_back(e);
  endtask

  // One clk cycle of stimulus. Inputs change 2 time units after negedge.
  task automatic apply(input bit v, input int d, input bit r);
    req_valid = v;
    req_div   = CNT_W'(d);
    if (r && !rst) begin
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_cur_div", cur_div, DEFAULT_DIV);
      check("async_rst_clkout", clkout, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_ready", req_ready, 1);
    end else begin
      rst = r;
    end
    @(posedge clk);
    model_step(v, d, r);
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 0, 1'b0);
  endtask

  // Monitor: every DUT cycle is an output beat; compare against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("tick", tick, e.tick);
        check("cur_div", cur_div, e.div);
        check("busy", busy, e.busy);
        check("req_ready", req_ready, e.ready);
        check("err", err, e.err);
        check("clkout_hi_half", clkout, e.c1);
        @(negedge clk);
        #1;
        check("clkout_lo_half", clkout, e.c2);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    model_reset();
    #2;
    // Reset held for a few cycles, then the default ratio free-runs.
    apply(1'b0, 0, 1'b1);
    apply(1'b0, 0, 1'b1);
    idle(10);
    // Ratio 4 requested mid-period.
    idle(1);
    apply(1'b1, 4, 1'b0);
    idle(12);
    // Illegal ratios are rejected with err.
    apply(1'b1, 1, 1'b0);
    idle(2);
    apply(1'b1, 0, 1'b0);
    idle(5);
    // Back to 3 so the remaining directed cases start from the default.
    apply(1'b1, 3, 1'b0);
    idle(10);
    // Ratio 5 accepted. A 7 offered while pending is ignored.
    apply(1'b1, 5, 1'b0);
    apply(1'b1, 7, 1'b0);
    apply(1'b1, 7, 1'b0);
    idle(12);
    // Reset while a ratio of 6 is pending.
    apply(1'b1, 6, 1'b0);
    apply(1'b0, 0, 1'b1);
    idle(9);
    // Request equal to the current ratio and the largest ratio.
    apply(1'b1, 3, 1'b0);
    idle(6);
    apply(1'b1, 15, 1'b0);
    idle(32);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit v, r;
      int d;
      v = ($urandom_range(0, 3) == 0);
      d = (($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 15));
      r = ($urandom_range(0, 299) == 0);
      apply(v, d, r);
    end
    idle(3);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
